uart_tx_engine: RTL

Transmit-side UART engine clocked on the oversampled `uart_clk`, the counterpart of the RX capture path. It accepts bytes over a valid/ready handshake into a small FIFO and serializes them onto `tx` as standard async frames: start bit, data LSB-first, optional parity, stop bit(s). Back-to-back frames are sent with no idle gap. It sits between the system-side producer, which is responsible for any clock-domain crossing, and the `tx` pin.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_fifo.sv | 65 ++++++
 rtl/uart_tx_engine.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the UART TX engine and the RX capture path.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_FIFO_DEPTH = 4;
    localparam int UART_STOP_BITS  = 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    // Parity over a zero-extended word; odd=1 selects odd parity.
    function automatic logic uart_parity(input logic [31:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO feeding the UART transmitter; head is readable
// combinationally so a pop edge can load the shift register directly.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     uart_clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [WIDTH-1:0] rd_words [DEPTH];
    logic             push_en;
    logic             pop_en;

    assign full     = (count_reg == (AW+1)'(DEPTH));
    assign empty    = (count_reg == '0);
    assign push_en  = push && !full;
    assign pop_en   = pop && !empty;
    assign count    = count_reg;
    assign pop_data = rd_words[rd_ptr_reg];

    always_ff @(posedge uart_clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + (AW+1)'(push_en) - (AW+1)'(pop_en);
        end
    end

    // Storage is never reset: flushing the pointers is enough to empty it.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;

            always_ff @(posedge uart_clk) begin
                if (push_en && (wr_ptr_reg == AW'(gi))) begin
                    entry_reg <= push_data;
                end
            end

            assign rd_words[gi] = entry_reg;
        end
    endgenerate

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: FIFO-buffered bytes serialized as start/data/[parity]/stop
// frames on the oversampled clock. Define UART_TX_PARITY_EN to add a parity bit.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int FIFO_DEPTH = UART_FIFO_DEPTH,
    parameter int STOP_BITS  = UART_STOP_BITS,
    parameter int PARITY_ODD = 0
) (
    input  logic                          uart_clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [DATA_BITS-1:0]          in_data,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam int BC_W = $clog2(DATA_BITS + 1);

    uart_tx_state_t       state_reg, state_next;
    logic [OS_W-1:0]      os_cnt_reg, os_cnt_next;
    logic [BC_W-1:0]      bit_cnt_reg, bit_cnt_next;
    logic [DATA_BITS-1:0] sh_reg, sh_next;
    logic                 tx_reg, tx_next;
    logic                 tx_done_reg, tx_done_next;
    logic                 os_wrap;
    logic                 start_frame;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_head;
`ifdef UART_TX_PARITY_EN
    logic                 par_reg, par_next;
`else
    logic                 unused_parity_odd;
    assign unused_parity_odd = (PARITY_ODD != 0);
`endif

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .uart_clk  (uart_clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign os_wrap = (os_cnt_reg == OS_W'(OVERSAMPLE - 1));

    always_ff @(posedge uart_clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            os_cnt_reg  <= '0;
            bit_cnt_reg <= '0;
            sh_reg      <= '0;
            tx_reg      <= 1'b1;
            tx_done_reg <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_reg     <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            os_cnt_reg  <= os_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            sh_reg      <= sh_next;
            tx_reg      <= tx_next;
            tx_done_reg <= tx_done_next;
`ifdef UART_TX_PARITY_EN
            par_reg     <= par_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        os_cnt_next  = os_wrap ? '0 : os_cnt_reg + 1'b1;
        bit_cnt_next = bit_cnt_reg;
        sh_next      = sh_reg;
        tx_next      = tx_reg;
        tx_done_next = 1'b0;
        start_frame  = 1'b0;
        fifo_pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_next     = par_reg;
`endif

        case (state_reg)
            IDLE: begin
                os_cnt_next = '0;
                tx_next     = 1'b1;
                start_frame = !fifo_empty;
            end
            START: begin
                if (os_wrap) begin
                    state_next   = DATA;
                    tx_next      = sh_reg[0];
                    sh_next      = sh_reg >> 1;
                    bit_cnt_next = '0;
                end
            end
            DATA: begin
                if (os_wrap) begin
                    if (bit_cnt_reg == BC_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_next   = PARITY;
                        tx_next      = par_reg;
`else
                        state_next   = STOP;
                        tx_next      = 1'b1;
                        bit_cnt_next = '0;
`endif
                    end else begin
                        tx_next      = sh_reg[0];
                        sh_next      = sh_reg >> 1;
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (os_wrap) begin
                    state_next   = STOP;
                    tx_next      = 1'b1;
                    bit_cnt_next = '0;
                end
            end
`endif
            STOP: begin
                if (os_wrap) begin
                    if (bit_cnt_reg == BC_W'(STOP_BITS - 1)) begin
                        tx_done_next = 1'b1;
                        state_next   = IDLE;
                        tx_next      = 1'b1;
                        start_frame  = !fifo_empty;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase

        // A pending byte starts its frame on this very edge, so frames abut.
        if (start_frame) begin
            fifo_pop    = 1'b1;
            sh_next     = fifo_head;
            tx_next     = 1'b0;
            os_cnt_next = '0;
            state_next  = START;
`ifdef UART_TX_PARITY_EN
            par_next    = uart_parity(32'(fifo_head), PARITY_ODD != 0);
`endif
        end
    end

    always_comb begin
        busy     = (state_reg != IDLE);
        tx       = tx_reg;
        tx_done  = tx_done_reg;
        in_ready = !fifo_full;
    end

endmodule
